// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, function
// fields, datapath select codes, ALU operations and the FSM state set.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_SLTU = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] EXT_I = 3'd0;
   localparam logic [2:0] EXT_S = 3'd1;
   localparam logic [2:0] EXT_B = 3'd2;
   localparam logic [2:0] EXT_J = 3'd3;
   localparam logic [2:0] EXT_U = 3'd4;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_PC     = 2'd2;
   localparam logic [1:0] RES_IMM    = 2'd3;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;
   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_IMM   = 2'd1;
   localparam logic [1:0] SRCB_FOUR  = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
   } state_e;

   function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                         input logic n, input logic c);
      logic t;
      t = 1'b0;
      case (f3)
         F3_BEQ:  t = z;
         F3_BNE:  t = !z;
         F3_BLT:  t = n;
         F3_BGE:  t = !n;
         F3_BLTU: t = c;
         F3_BGEU: t = !c;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for OP and OP-IMM instructions; also
// reports whether the func3/func7 combination is a supported encoding.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic [3:0] aluop,
   output logic       legal
);

   logic is_r;
   logic base;
   logic alt;

   always_comb begin
      is_r  = (op == OPC_OP);
      base  = (func7 == F7_BASE);
      alt   = (func7 == F7_ALT);
      aluop = ALU_ADD;
      legal = 1'b1;
      if (is_r || op == OPC_OP_IMM) begin
         // Immediate forms carry imm bits in func7, so only shifts constrain it.
         case (func3)
            F3_ADD:  begin aluop = (is_r && alt) ? ALU_SUB : ALU_ADD; legal = !is_r || base || alt; end
            F3_SLL:  begin aluop = ALU_SLL;  legal = base; end
            F3_SLT:  begin aluop = ALU_SLT;  legal = !is_r || base; end
            F3_SLTU: begin aluop = ALU_SLTU; legal = !is_r || base; end
            F3_XOR:  begin aluop = ALU_XOR;  legal = !is_r || base; end
            F3_SR:   begin aluop = alt ? ALU_SRA : ALU_SRL; legal = base || alt; end
            F3_OR:   begin aluop = ALU_OR;   legal = !is_r || base; end
            F3_AND:  begin aluop = ALU_AND;  legal = !is_r || base; end
            default: begin aluop = ALU_ADD;  legal = 1'b0; end
         endcase
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences shared memory, ALU and IR/ALUOut/
// OldPC over 3-5 states per instruction, with mem_ready wait states.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int ALUOP_W       = 4,
   parameter bit RESET_PC_HOLD = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         op,
   input  logic [2:0]         func3,
   input  logic [6:0]         func7,
   input  logic               zero,
   input  logic               negetive,
   input  logic               carry,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               memwrite,
   output logic               adrsrc,
   output logic               irwrite,
   output logic               pcwrite,
   output logic               pcsrc,
   output logic               regwrite,
   output logic [1:0]         resultsrc,
   output logic [1:0]         alusrca,
   output logic [1:0]         alusrcb,
   output logic [ALUOP_W-1:0] aluop,
   output logic [2:0]         extend_func,
   output logic               illegal
);

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       hold_q, hold_d;
   logic [3:0] dec_aluop;
   logic       dec_legal;
   logic [3:0] alu_code;

   alu_decoder u_alu_decoder (
      .op    (op),
      .func3 (func3),
      .func7 (func7),
      .aluop (dec_aluop),
      .legal (dec_legal)
   );

   assign aluop   = ALUOP_W'(alu_code);
   assign illegal = illegal_q;

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      hold_d      = 1'b0;
      mem_req     = 1'b0;
      memwrite    = 1'b0;
      adrsrc      = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      pcsrc       = 1'b0;
      regwrite    = 1'b0;
      resultsrc   = RES_ALUOUT;
      alusrca     = SRCA_PC;
      alusrcb     = SRCB_RS2;
      alu_code    = ALU_ADD;
      extend_func = EXT_I;
      // Reset and the post-reset hold cycle both keep every output quiet.
      if (!rst && !hold_q) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               alusrcb = SRCB_FOUR;
               if (mem_ready) begin
                  irwrite = 1'b1;
                  pcwrite = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               alusrca = SRCA_OLDPC;
               alusrcb = SRCB_IMM;
               case (op)
                  OPC_OP:              state_d = dec_legal ? S_EXEC_R : S_TRAP;
                  OPC_OP_IMM:          state_d = dec_legal ? S_EXEC_I : S_TRAP;
                  OPC_LOAD, OPC_STORE: state_d = (func3 == F3_WORD) ? S_MEM_ADDR : S_TRAP;
                  OPC_BRANCH: begin
                     extend_func = EXT_B;
                     state_d = (func3 == F3_SLT || func3 == F3_SLTU) ? S_TRAP : S_BRANCH;
                  end
                  OPC_JAL: begin
                     extend_func = EXT_J;
                     state_d     = S_JAL;
                  end
                  OPC_JALR:            state_d = (func3 == F3_JALR) ? S_JALR : S_TRAP;
                  OPC_LUI:             state_d = S_LUI;
                  default:             state_d = S_TRAP;
               endcase
               illegal_d = (state_d == S_TRAP);
            end
            S_EXEC_R, S_EXEC_I: begin
               alusrca  = SRCA_RS1;
               alusrcb  = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
               alu_code = dec_aluop;
               state_d  = S_WB_ALU;
            end
            S_MEM_ADDR: begin
               alusrca     = SRCA_RS1;
               alusrcb     = SRCB_IMM;
               extend_func = (op == OPC_STORE) ? EXT_S : EXT_I;
               state_d     = (op == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               adrsrc  = 1'b1;
               if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               memwrite = 1'b1;
               adrsrc   = 1'b1;
               if (mem_ready) state_d = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM: begin
               regwrite  = 1'b1;
               resultsrc = (state_q == S_WB_MEM) ? RES_MEM : RES_ALUOUT;
               state_d   = S_FETCH;
            end
            S_BRANCH: begin
               alusrca  = SRCA_RS1;
               alusrcb  = SRCB_RS2;
               alu_code = ALU_SUB;
               pcsrc    = 1'b1;
               pcwrite  = branch_taken(func3, zero, negetive, carry);
               state_d  = S_FETCH;
            end
            S_JAL: begin
               pcwrite   = 1'b1;
               pcsrc     = 1'b1;
               regwrite  = 1'b1;
               resultsrc = RES_PC;
               state_d   = S_FETCH;
            end
            S_JALR: begin
               alusrca   = SRCA_RS1;
               alusrcb   = SRCB_IMM;
               pcwrite   = 1'b1;
               regwrite  = 1'b1;
               resultsrc = RES_PC;
               state_d   = S_FETCH;
            end
            S_LUI: begin
               regwrite    = 1'b1;
               resultsrc   = RES_IMM;
               extend_func = EXT_U;
               state_d     = S_FETCH;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         hold_q    <= RESET_PC_HOLD;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         hold_q    <= hold_d;
      end
   end

endmodule
